iob_regfile_drain: RTL and testbench

IOB_REGFILE_DRAIN -- requirements
Module: iob_regfile_drain

---
 rtl/iob_regfile_drain_pkg.sv | 11 +
 rtl/iob_regfile_sp.sv | 25 ++
 rtl/iob_regfile_drain.sv | 97 +++++++++
 tb/tb_iob_regfile_drain.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/iob_regfile_drain_pkg.sv
// Shared types for the register-file drain engine.
package iob_regfile_drain_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        SEND  = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/iob_regfile_sp.sv
// Single-port register file: one shared address, synchronous write, combinational read.
// No content reset, so entries survive a reset of the drain engine.
module iob_regfile_sp #(
    parameter int ADDR_W = 2,
    parameter int DATA_W = 32
) (
    input  logic              ap_clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] addr,
    input  logic              we,
    input  logic [DATA_W-1:0] w_data,
    output logic [DATA_W-1:0] r_data
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge ap_clk) begin
        if (!rst && we) begin
            mem[addr] <= w_data;
        end
    end

    assign r_data = mem[addr];

endmodule

// File: rtl/iob_regfile_drain.sv
// Drains every register-file entry onto a valid/ready stream, one word per two cycles.
// Optional clear-on-read when IOB_REGFILE_DRAIN_CLEAR_EN is defined.
module iob_regfile_drain
    import iob_regfile_drain_pkg::*;
#(
    parameter int ADDR_W = 2,
    parameter int DATA_W = 32
) (
    input  logic              ap_clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] rf_addr,
    output logic              rf_we,
    output logic [DATA_W-1:0] rf_w_data,
    input  logic [DATA_W-1:0] rf_r_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic [ADDR_W-1:0] m_addr,
    output logic              m_last
);

    localparam logic [ADDR_W-1:0] LAST_IDX = '1;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] idx, idx_nxt;
    logic              start_q;
    logic              start_rise;
    logic              hs;

    // Only a rising start launches a drain, so a level held past DONE
    // cannot retrigger a second pass.
    assign start_rise = start && !start_q;
    assign hs         = (state == SEND) && m_ready && !rst;

    always_ff @(posedge ap_clk) begin
        if (rst) begin
            state   <= IDLE;
            idx     <= '0;
            start_q <= 1'b0;
            m_data  <= '0;
            m_addr  <= '0;
            m_last  <= 1'b0;
        end else begin
            state   <= state_nxt;
            idx     <= idx_nxt;
            start_q <= start;
            if (state == FETCH) begin
                m_data <= rf_r_data;
                m_addr <= idx;
                m_last <= (idx == LAST_IDX);
            end
        end
    end

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        case (state)
            IDLE: begin
                if (start_rise) begin
                    state_nxt = FETCH;
                    idx_nxt   = '0;
                end
            end
            FETCH: state_nxt = SEND;
            SEND: begin
                if (hs) begin
                    if (idx == LAST_IDX) begin
                        state_nxt = DONE;
                    end else begin
                        idx_nxt   = idx + 1'b1;
                        state_nxt = FETCH;
                    end
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs are masked by rst so reset takes effect in the same cycle.
    assign m_valid   = (state == SEND) && !rst;
    assign busy      = (state != IDLE) && !rst;
    assign done      = (state == DONE) && !rst;
    assign rf_addr   = (!rst && (state == FETCH || state == SEND)) ? idx : '0;
    assign rf_w_data = '0;

`ifdef IOB_REGFILE_DRAIN_CLEAR_EN
    assign rf_we = hs;
`else
    assign rf_we = 1'b0;
`endif

endmodule

// File: tb/tb_iob_regfile_drain.sv
// Scoreboard bench for iob_regfile_drain with an iob_regfile_sp behind it.
module tb_iob_regfile_drain;

    localparam int ADDR_W = 2;
    localparam int DATA_W = 32;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic              last;
    } beat_t;

    logic              ap_clk = 1'b0;
    logic              rst, start, busy, done, rf_we, m_valid, m_ready, m_last;
    logic [ADDR_W-1:0] rf_addr, m_addr;
    logic [DATA_W-1:0] rf_w_data, rf_r_data, m_data;

    // Bench-side access to the register file for preload and inspection.
    logic              tb_sel, tb_we;
    logic [ADDR_W-1:0] tb_addr;
    logic [DATA_W-1:0] tb_wdata;
    logic [ADDR_W-1:0] mux_addr;
    logic              mux_we;
    logic [DATA_W-1:0] mux_wdata;

    assign mux_addr  = tb_sel ? tb_addr  : rf_addr;
    assign mux_we    = tb_sel ? tb_we    : rf_we;
    assign mux_wdata = tb_sel ? tb_wdata : rf_w_data;

    always #5 ap_clk = ~ap_clk;

    iob_regfile_drain #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .ap_clk(ap_clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .rf_addr(rf_addr), .rf_we(rf_we), .rf_w_data(rf_w_data), .rf_r_data(rf_r_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_addr(m_addr),
        .m_last(m_last)
    );

    iob_regfile_sp #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_rf (
        .ap_clk(ap_clk), .rst(rst), .addr(mux_addr), .we(mux_we),
        .w_data(mux_wdata), .r_data(rf_r_data)
    );

    int    checks = 0;
    int    errors = 0;
    beat_t exp_q[$];
    int    done_cnt = 0;
    int    we_cnt = 0;
    int    beats_cnt = 0;
    int    cyc = 0;
    int    last_hs_cyc = 0;
    bit    gap_chk = 0;
    bit    first_hs = 0;
    bit    hold_chk = 0;
    bit    prev_done = 0;
    beat_t held;

    task automatic chk(input string name, input logic [DATA_W-1:0] act,
                       input logic [DATA_W-1:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
        end
    endtask

    // Monitor: pops the scoreboard on every handshake, checks hold stability,
    // beat spacing and the done pulse.
    always @(negedge ap_clk) begin
        cyc++;
        if (rst) begin
            hold_chk  = 0;
            prev_done = 0;
        end else begin
            if (hold_chk) begin
                chk("hold_valid", {31'd0, m_valid}, 32'd1);
                chk("hold_data", m_data, held.data);
                chk("hold_addr", {30'd0, m_addr}, {30'd0, held.addr});
                chk("hold_last", {31'd0, m_last}, {31'd0, held.last});
            end
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat: got addr=%0d data=0x%0h expected none",
                             m_addr, m_data);
                end else begin
                    beat_t e;
                    e = exp_q.pop_front();
                    chk("beat_addr", {30'd0, m_addr}, {30'd0, e.addr});
                    chk("beat_data", m_data, e.data);
                    chk("beat_last", {31'd0, m_last}, {31'd0, e.last});
                end
                if (gap_chk && !first_hs)
                    chk("beat_gap", cyc - last_hs_cyc, 32'd2);
                first_hs    = 0;
                last_hs_cyc = cyc;
                beats_cnt++;
            end
            hold_chk = m_valid && !m_ready;
            held.data = m_data;
            held.addr = m_addr;
            held.last = m_last;
            if (done) begin
                done_cnt++;
                if (prev_done) chk("done_width", 32'd2, 32'd1);
            end
            prev_done = done;
            if (rf_we) we_cnt++;
        end
    end

    task automatic preload();
        tb_sel = 1;
        for (int i = 0; i < 4; i++) begin
            tb_addr  = ADDR_W'(i);
            tb_we    = 1;
            tb_wdata = 32'hA0 + i;
            @(posedge ap_clk); #1;
        end
        tb_we  = 0;
        tb_sel = 0;
    endtask

    task automatic push4(input logic [DATA_W-1:0] d0, d1, d2, d3);
        beat_t b;
        b.addr = 2'd0; b.data = d0; b.last = 0; exp_q.push_back(b);
        b.addr = 2'd1; b.data = d1; b.last = 0; exp_q.push_back(b);
        b.addr = 2'd2; b.data = d2; b.last = 0; exp_q.push_back(b);
        b.addr = 2'd3; b.data = d3; b.last = 1; exp_q.push_back(b);
    endtask

    task automatic pulse_start();
        start = 1;
        @(posedge ap_clk); #1;
        start = 0;
    endtask

    task automatic wait_done(input int d0, input string name);
        int n = 0;
        while (done_cnt == d0 && n < 200) begin
            @(posedge ap_clk);
            n++;
        end
        if (n >= 200) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got no done expected done within 200 cycles", name);
        end
        repeat (3) @(posedge ap_clk);
        #1;
        chk({name, "_done_cnt"}, done_cnt, d0 + 1);
        chk({name, "_queue_empty"}, exp_q.size(), 32'd0);
    endtask

    task automatic read_rf(input int i, input logic [DATA_W-1:0] expv, input string name);
        tb_sel  = 1;
        tb_addr = ADDR_W'(i);
        @(negedge ap_clk);
        chk(name, rf_r_data, expv);
        @(posedge ap_clk); #1;
        tb_sel = 0;
    endtask

    initial begin
        int d0;
        int n;
        logic [DATA_W-1:0] e0, e1;
        rst = 1; start = 0; m_ready = 1;
        tb_sel = 0; tb_we = 0; tb_addr = '0; tb_wdata = '0;
        held.addr = '0; held.data = '0; held.last = 0;
        repeat (3) @(posedge ap_clk);
        @(negedge ap_clk);
        chk("rst_m_valid", {31'd0, m_valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_rf_we", {31'd0, rf_we}, 32'd0);
        chk("rst_rf_addr", {30'd0, rf_addr}, 32'd0);
        chk("rst_rf_w_data", rf_w_data, 32'd0);
        chk("rst_m_data", m_data, 32'd0);
        chk("rst_m_addr", {30'd0, m_addr}, 32'd0);
        chk("rst_m_last", {31'd0, m_last}, 32'd0);
        @(posedge ap_clk); #1;
        rst = 0;

        // Basic drain with latency and spacing.
        preload();
        push4(32'hA0, 32'hA1, 32'hA2, 32'hA3);
        gap_chk = 1; first_hs = 1;
        d0 = done_cnt;
        pulse_start();
        @(negedge ap_clk);
        chk("lat_fetch_valid", {31'd0, m_valid}, 32'd0);
        chk("lat_busy", {31'd0, busy}, 32'd1);
        @(negedge ap_clk);
        chk("lat_send_valid", {31'd0, m_valid}, 32'd1);
        wait_done(d0, "basic");
        gap_chk = 0;

        // Backpressure: beat 1 stalled three extra cycles.
        preload();
        push4(32'hA0, 32'hA1, 32'hA2, 32'hA3);
        m_ready = 0;
        d0 = done_cnt;
        pulse_start();
        for (int b = 0; b < 4; b++) begin
            n = 0;
            do begin
                @(negedge ap_clk);
                n++;
            end while (!m_valid && n < 50);
            if (b == 1) repeat (3) @(posedge ap_clk);
            @(posedge ap_clk); #1;
            m_ready = 1;
            @(posedge ap_clk); #1;
            m_ready = 0;
        end
        m_ready = 1;
        wait_done(d0, "stall");

        // Start level held for 20 cycles launches exactly one drain.
        preload();
        push4(32'hA0, 32'hA1, 32'hA2, 32'hA3);
        d0 = done_cnt;
        start = 1;
        repeat (20) @(posedge ap_clk);
        #1;
        start = 0;
        wait_done(d0, "held");

        // Register file state after drains, then a second drain of it.
`ifdef IOB_REGFILE_DRAIN_CLEAR_EN
        for (int i = 0; i < 4; i++) read_rf(i, 32'h0, "cleared_entry");
        push4(32'h0, 32'h0, 32'h0, 32'h0);
`else
        for (int i = 0; i < 4; i++) read_rf(i, 32'hA0 + i, "kept_entry");
        push4(32'hA0, 32'hA1, 32'hA2, 32'hA3);
`endif
        d0 = done_cnt;
        pulse_start();
        wait_done(d0, "second");
`ifndef IOB_REGFILE_DRAIN_CLEAR_EN
        chk("rf_we_never", we_cnt, 32'd0);
`endif

        // Reset after beat 1, then restart from index 0.
        preload();
        begin
            beat_t b;
            b.addr = 2'd0; b.data = 32'hA0; b.last = 0; exp_q.push_back(b);
            b.addr = 2'd1; b.data = 32'hA1; b.last = 0; exp_q.push_back(b);
        end
        beats_cnt = 0;
        d0 = done_cnt;
        pulse_start();
        n = 0;
        while (beats_cnt < 2 && n < 100) begin
            @(posedge ap_clk);
            n++;
        end
        #1;
        rst = 1;
        @(posedge ap_clk);
        @(negedge ap_clk);
        chk("abort_m_valid", {31'd0, m_valid}, 32'd0);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_m_data", m_data, 32'd0);
        chk("abort_m_addr", {30'd0, m_addr}, 32'd0);
        chk("abort_m_last", {31'd0, m_last}, 32'd0);
        chk("abort_rf_addr", {30'd0, rf_addr}, 32'd0);
        @(posedge ap_clk); #1;
        rst = 0;
        repeat (3) @(posedge ap_clk);
        #1;
        chk("abort_no_done", done_cnt, d0);
        chk("abort_queue_empty", exp_q.size(), 32'd0);
`ifdef IOB_REGFILE_DRAIN_CLEAR_EN
        e0 = 32'h0; e1 = 32'h0;
`else
        e0 = 32'hA0; e1 = 32'hA1;
`endif
        read_rf(2, 32'hA2, "abort_keep2");
        read_rf(3, 32'hA3, "abort_keep3");
        push4(e0, e1, 32'hA2, 32'hA3);
        d0 = done_cnt;
        pulse_start();
        wait_done(d0, "restart");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
